// File: rtl/addr_decode_arb_if.sv
// Request/acknowledge and decoded-access signals between the CPU-side requesters
// and the address decoder/arbiter.
interface addr_decode_arb_if #(
  parameter int AW       = 8,
  parameter int IO_PORTS = 8
);
  logic                i_req;
  logic [AW-1:0]       i_addr;
  logic                i_ack;
  logic                d_req;
  logic [AW-1:0]       d_addr;
  logic                d_ack;
  logic                mem_en;
  logic [AW-1:0]       mem_addr;
  logic [IO_PORTS-1:0] io_sel;
  logic                busy;

  modport master (
    output i_req, i_addr, d_req, d_addr,
    input  i_ack, d_ack, mem_en, mem_addr, io_sel, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr,
    output i_ack, d_ack, mem_en, mem_addr, io_sel, busy
  );
endinterface

// File: rtl/addr_decode_arb.sv
// Registered arbiter between instruction-fetch and data requests; decodes the granted
// address into a memory access or a one-hot I/O select and holds it for a wait count.
module addr_decode_arb #(
  parameter int AW       = 8,
  parameter int IO_PORTS = 8,
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  addr_decode_arb_if.slave  bus
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_MEM   = 2'd1;
  localparam logic [1:0]    S_IO    = 2'd2;
  localparam logic [AW-1:0] IO_BASE = AW'((1 << AW) - IO_PORTS);
  localparam logic [3:0]    MEM_W   = 4'(MEM_WAIT);
  localparam logic [3:0]    IO_W    = 4'(IO_WAIT);

  logic [1:0]          r_state;
  logic [3:0]          r_cnt;
  logic                r_last_d;
  logic [AW-1:0]       r_mem_addr;
  logic [IO_PORTS-1:0] r_io_sel;
  logic                r_i_ack;
  logic                r_d_ack;

  logic                w_any_req;
  logic                w_gnt_d;
  logic                w_is_io;
  logic [3:0]          w_wait;
  logic [AW-1:0]       w_port;
  logic [IO_PORTS-1:0] w_onehot;

  assign w_any_req = bus.i_req | bus.d_req;

  // Data wins a tie unless the previous grant already went to data.
  always_comb begin
    w_onehot = '0;
    w_gnt_d  = bus.d_req && (!bus.i_req || !r_last_d);
    w_is_io  = w_gnt_d && (bus.d_addr >= IO_BASE);
    w_wait   = w_is_io ? IO_W : MEM_W;
    w_port   = bus.d_addr - IO_BASE;
    for (int k = 0; k < IO_PORTS; k++) begin
      w_onehot[k] = (w_port == AW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_last_d   <= 1'b0;
      r_mem_addr <= '0;
      r_io_sel   <= '0;
      r_i_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= w_is_io ? S_IO : S_MEM;
            r_cnt      <= w_wait;
            r_last_d   <= w_gnt_d;
            r_mem_addr <= w_is_io ? '0 : (w_gnt_d ? bus.d_addr : bus.i_addr);
            r_io_sel   <= w_is_io ? w_onehot : '0;
            r_i_ack    <= !w_gnt_d && (w_wait == 4'd0);
            r_d_ack    <= w_gnt_d && (w_wait == 4'd0);
          end
        end
        S_MEM, S_IO: begin
          if (r_cnt == 4'd0) begin
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
            r_io_sel   <= '0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
          end else begin
            // Ack is registered one edge early so it lands on the final access cycle.
            r_cnt   <= r_cnt - 4'd1;
            r_i_ack <= !r_last_d && (r_cnt == 4'd1);
            r_d_ack <= r_last_d && (r_cnt == 4'd1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_en   = (r_state == S_MEM);
  assign bus.mem_addr = r_mem_addr;
  assign bus.io_sel   = r_io_sel;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.i_ack    = r_i_ack;
  assign bus.d_ack    = r_d_ack;

endmodule

// File: tb/tb_addr_decode_arb.sv
// Directed bench for addr_decode_arb: three parameterisations, expectations queued
// when a request is driven and consumed as the access appears on the outputs.
module tb_addr_decode_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  addr_decode_arb_if #(.AW(8),  .IO_PORTS(8))  ifa ();
  addr_decode_arb_if #(.AW(8),  .IO_PORTS(8))  ifb ();
  addr_decode_arb_if #(.AW(10), .IO_PORTS(16)) ifc ();

  addr_decode_arb #(.AW(8), .IO_PORTS(8), .MEM_WAIT(0), .IO_WAIT(2))
    ua (.clk(clk), .rst_n(rst_a), .bus(ifa));
  addr_decode_arb #(.AW(8), .IO_PORTS(8), .MEM_WAIT(1), .IO_WAIT(2))
    ub (.clk(clk), .rst_n(rst_b), .bus(ifb));
  addr_decode_arb #(.AW(10), .IO_PORTS(16), .MEM_WAIT(0), .IO_WAIT(2))
    uc (.clk(clk), .rst_n(rst_c), .bus(ifc));

  typedef struct {
    logic        is_d;
    logic        is_io;
    logic [15:0] addr;
    logic [15:0] sel;
    int          w;
  } exp_t;

  exp_t sb[$];
  bit   ackq[$];
  int   npass  = 0;
  int   ntotal = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One access on instance A; request dropped and address scrambled right after grant.
  task automatic access_a(input logic is_d, input logic [7:0] addr, input string tag);
    exp_t e, g;
    e.is_d  = is_d;
    e.is_io = is_d && (addr >= 8'hF8);
    e.addr  = {8'h00, addr};
    e.sel   = e.is_io ? (16'd1 << (addr - 8'hF8)) : 16'd0;
    e.w     = e.is_io ? 2 : 0;
    sb.push_back(e);
    @(posedge clk); #1;
    if (is_d) begin ifa.d_req = 1'b1; ifa.d_addr = addr; end
    else      begin ifa.i_req = 1'b1; ifa.i_addr = addr; end
    @(posedge clk); #1;
    ifa.d_req  = 1'b0;
    ifa.i_req  = 1'b0;
    ifa.d_addr = ~addr;
    ifa.i_addr = ~addr;
    g = sb.pop_front();
    for (int c = 0; c <= g.w; c++) begin
      @(negedge clk);
      check({tag, ".busy"},     ifa.busy,     32'd1);
      check({tag, ".mem_en"},   ifa.mem_en,   {31'd0, !g.is_io});
      check({tag, ".mem_addr"}, ifa.mem_addr, g.is_io ? 32'd0 : {16'd0, g.addr});
      check({tag, ".io_sel"},   ifa.io_sel,   {16'd0, g.sel});
      check({tag, ".i_ack"},    ifa.i_ack,    {31'd0, !g.is_d && (c == g.w)});
      check({tag, ".d_ack"},    ifa.d_ack,    {31'd0, g.is_d && (c == g.w)});
    end
    @(negedge clk);
    check({tag, ".idle_busy"},   ifa.busy,   32'd0);
    check({tag, ".idle_mem_en"}, ifa.mem_en, 32'd0);
    check({tag, ".idle_io_sel"}, ifa.io_sel, 32'd0);
    check({tag, ".idle_acks"},   {ifa.i_ack, ifa.d_ack}, 32'd0);
  endtask

  task automatic access_c(input logic [9:0] addr, input string tag, input logic [15:0] exp_sel,
                          input logic [9:0] exp_maddr, input logic exp_men, input int exp_w);
    int n;
    @(posedge clk); #1;
    ifc.d_req  = 1'b1;
    ifc.d_addr = addr;
    @(posedge clk); #1;
    ifc.d_req  = 1'b0;
    @(negedge clk);
    check({tag, ".io_sel"},   ifc.io_sel,   {16'd0, exp_sel});
    check({tag, ".mem_addr"}, ifc.mem_addr, {22'd0, exp_maddr});
    check({tag, ".mem_en"},   ifc.mem_en,   {31'd0, exp_men});
    n = 0;
    while (!ifc.d_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".ack_cycle"}, n, exp_w);
    @(negedge clk);
    check({tag, ".idle_busy"}, ifc.busy, 32'd0);
  endtask

  initial begin
    int   last;
    bit   want;
    logic saw;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ifa.i_req = 1'b0; ifa.d_req = 1'b0; ifa.i_addr = '0; ifa.d_addr = '0;
    ifc.i_req = 1'b0; ifc.d_req = 1'b0; ifc.i_addr = '0; ifc.d_addr = '0;
    ifb.i_req = 1'b1; ifb.d_req = 1'b1; ifb.i_addr = 8'h20; ifb.d_addr = 8'h30;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy",   ifa.busy,   32'd0);
    check("rst.mem_en", ifa.mem_en, 32'd0);
    check("rst.io_sel", ifa.io_sel, 32'd0);
    check("rst.acks",   {ifa.i_ack, ifa.d_ack}, 32'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Contention on B: both requests held from reset, expect D, I, D, I every 3 cycles.
    ackq = '{1'b1, 1'b0, 1'b1, 1'b0};
    last = -1;
    for (int cyc = 0; cyc < 60 && ackq.size() > 0; cyc++) begin
      @(negedge clk);
      if (ifb.i_ack || ifb.d_ack) begin
        want = ackq.pop_front();
        check("arb.two_acks", {31'd0, ifb.i_ack && ifb.d_ack}, 32'd0);
        check("arb.winner_is_d", ifb.d_ack, {31'd0, want});
        if (last >= 0) check("arb.ack_gap", cyc - last, 32'd3);
        last = cyc;
      end
    end
    check("arb.all_grants_seen", ackq.size(), 32'd0);
    ifb.i_req = 1'b0;
    ifb.d_req = 1'b0;

    access_a(1'b1, 8'h10, "dmem_10");
    access_a(1'b1, 8'hFA, "io_fa");
    access_a(1'b1, 8'hF7, "dmem_f7");
    access_a(1'b1, 8'hF8, "io_f8");
    access_a(1'b1, 8'hFF, "io_ff");
    access_a(1'b0, 8'hFC, "ifetch_fc");

    // Reset asserted mid I/O access, between clock edges.
    @(posedge clk); #1;
    ifa.d_req = 1'b1; ifa.d_addr = 8'hFA;
    @(posedge clk); #1;
    ifa.d_req = 1'b0;
    @(negedge clk);
    check("midrst.pre_io_sel", ifa.io_sel, 32'h04);
    #1 rst_a = 1'b0;
    #1;
    check("midrst.io_sel", ifa.io_sel, 32'd0);
    check("midrst.mem_en", ifa.mem_en, 32'd0);
    check("midrst.busy",   ifa.busy,   32'd0);
    check("midrst.acks",   {ifa.i_ack, ifa.d_ack}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw = saw | ifa.d_ack;
    end
    check("midrst.no_late_ack", saw, 32'd0);
    access_a(1'b1, 8'hFA, "post_rst_io");

    access_c(10'h3F0, "c_io_3f0",  16'h0001, 10'h000, 1'b0, 2);
    access_c(10'h3EF, "c_mem_3ef", 16'h0000, 10'h3EF, 1'b1, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
